fake_sram_1r1w: RTL and testbench
=================================

// Module: fake_sram_1r1w
// PURPOSE
//  Next-generation synthesizable flop-based memory for ASAP7 flows (no SRAM macro).
//  Independent write and read ports with valid/ready handshakes.
//  Read latency is configurable; byte enables scale with the data width.
//  Same-cycle read/write collisions follow a defined policy.
//  Used as the instruction/data store behind the core's memory interface.
// PARAMETERS
//  DATA_WIDTH  32               word width; must be a multiple of 8 (elaboration error otherwise)
//  ADDR_WIDTH  10               address width
//  DEPTH       1<<ADDR_WIDTH    number of words; must be <= 2**ADDR_WIDTH
//  OUT_REG     0                0: read latency 1 cycle; 1: extra output register, latency 2
//  WR_FIRST    1                collision policy: 1 = read returns new data, 0 = read returns old data
// PORTS
//  clk        in   1             clock; all logic on the rising edge
//  rst        in   1             synchronous, active-high reset
//  wr_valid   in   1             write request
//  wr_ready   out  1             write port can accept
//  wr_addr    in   ADDR_WIDTH    write word address
//  wr_be      in   DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i]
//  wr_data    in   DATA_WIDTH    write data
//  rd_valid   in   1             read request
//  rd_ready   out  1             read port can accept
//  rd_addr    in   ADDR_WIDTH    read word address
//  rd_rvalid  out  1             read data valid; single-cycle pulse; no backpressure
//  rd_data    out  DATA_WIDTH    read data; holds its last value when rd_rvalid=0
// BEHAVIOUR
//  - Handshakes: write accepted when wr_valid&wr_ready; read accepted when rd_valid&rd_ready.
//    Both ports may be accepted in the same cycle.
//  - Reset values: wr_ready=0, rd_ready=0, rd_rvalid=0, rd_data=0, pipeline valids=0.
//    Array contents are not reset, except as given under CONFIGURATION.
//  - FSM states: RESET -> (CLEAR) -> RUN.
//    In RUN: wr_ready=rd_ready=1 every cycle. rst in any state returns to RESET.
//  - Write: accepted write updates only the enabled bytes at the clock edge.
//    wr_be=0 is accepted and changes nothing.
//  - Read: data for a read accepted at edge N is presented with rd_rvalid=1 in the cycle after edge N+OUT_REG.
//    Latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
//    Back-to-back reads give one result per cycle, in order.
//  - Collision (same-cycle write and read, same address):
//    WR_FIRST=1: enabled bytes come from wr_data, other bytes hold stored data.
//    WR_FIRST=0: read returns pre-write contents.
//  - Out of range (addr >= DEPTH): the write is accepted and ignored; the read returns 0 with a normal rd_rvalid.
//  - Reset mid-operation: in-flight reads are dropped and rd_rvalid=0 from the cycle after rst.
//    Writes committed before rst persist.
// CONFIGURATION
//  FAKE_SRAM_1R1W_CLEAR_EN defined:
//  - After rst deasserts, the CLEAR state writes 0 to address 0..DEPTH-1, one word per cycle, via an internal counter.
//  - wr_ready=rd_ready=0 during CLEAR. RUN is entered, and both readies go to 1, exactly DEPTH cycles after rst deasserts.
//  - rst during CLEAR restarts the clear at address 0.
//  FAKE_SRAM_1R1W_CLEAR_EN undefined:
//  - No CLEAR state. RESET goes to RUN on the first edge with rst=0, so both readies go to 1 one cycle after rst deasserts.
//  - Array contents are undefined until written.
// TESTING
//  1. Write 0xDEADBEEF to addr 5 (be=4'hF); read addr 5 -> rd_data=0xDEADBEEF, rd_rvalid after 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles.
//  2. Mem[3]=0x11223344; write be=4'b0101 data 0xAABBCCDD to addr 3; read -> 0x11BB33DD.
//  3. Collision, addr 7 old 0x0, write 0xFFFFFFFF be=4'hF: WR_FIRST=1 -> 0xFFFFFFFF; WR_FIRST=0 -> 0x00000000.
//  4. Reads of addr 0,1,2,3 in consecutive cycles -> 4 consecutive rd_rvalid pulses, data in order.
//  5. rst asserted with 2 reads in flight -> no rd_rvalid after rst; data written earlier still reads back.
//  6. CLEAR_EN, DEPTH=16: readies low for 16 cycles after rst deasserts; every address then reads 0.

Source files
------------

// File: rtl/fake_sram_1r1w.sv
// ============================================================================
// Module   : fake_sram_1r1w
// Brief    : Flop-based 1R1W memory with valid/ready ports, byte enables,
//            configurable read latency and collision policy.
//            Optional power-up clear: define FAKE_SRAM_1R1W_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fake_sram_1r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int OUT_REG    = 0,
  parameter int WR_FIRST   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_valid_i,
  output logic                    rd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic                    rd_rvalid_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o
);

  localparam int c_num_bytes = DATA_WIDTH / 8;
  localparam int c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]  c_depth     = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [c_idx_w-1:0]   c_last_addr = c_idx_w'(DEPTH - 1);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("fake_sram_1r1w: DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH > (1 << ADDR_WIDTH) || DEPTH < 1) begin : g_bad_depth
    $error("fake_sram_1r1w: DEPTH must be in 1..2**ADDR_WIDTH");
  end

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    wr_ready_q;
  logic                    rd_ready_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    rd_v1_q;
  logic [DATA_WIDTH-1:0]   rd_d1_q;
  logic [DATA_WIDTH-1:0]   rd_data_d;

  logic                    w_wr_in_range;
  logic                    w_rd_in_range;
  logic                    w_wr_we;
  logic                    w_rd_fire;
  logic [c_idx_w-1:0]      w_wr_idx;
  logic [c_idx_w-1:0]      w_rd_idx;
  logic                    w_clr_we;
  logic [c_idx_w-1:0]      w_clr_addr;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign w_wr_in_range = ({1'b0, wr_addr_i} < c_depth);
  assign w_rd_in_range = ({1'b0, rd_addr_i} < c_depth);
  assign w_wr_idx      = wr_addr_i[c_idx_w-1:0];
  assign w_rd_idx      = rd_addr_i[c_idx_w-1:0];
  assign w_wr_we       = wr_valid_i & wr_ready_q & w_wr_in_range;
  assign w_rd_fire     = rd_valid_i & rd_ready_q;

`ifdef FAKE_SRAM_1R1W_CLEAR_EN
  logic [c_idx_w-1:0] clr_cnt_q;

  assign w_clr_we   = !rst && (state_q == S_RESET || state_q == S_CLEAR);
  assign w_clr_addr = clr_cnt_q;
`else
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  // The clear begins on the first edge after reset so RUN lands exactly DEPTH edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      wr_ready_q <= 1'b0;
      rd_ready_q <= 1'b0;
`ifdef FAKE_SRAM_1R1W_CLEAR_EN
      clr_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_RESET, S_CLEAR: begin
`ifdef FAKE_SRAM_1R1W_CLEAR_EN
          if (clr_cnt_q == c_last_addr) begin
            state_q    <= S_RUN;
            wr_ready_q <= 1'b1;
            rd_ready_q <= 1'b1;
          end else begin
            state_q    <= S_CLEAR;
            clr_cnt_q  <= clr_cnt_q + 1'b1;
          end
`else
          state_q    <= S_RUN;
          wr_ready_q <= 1'b1;
          rd_ready_q <= 1'b1;
`endif
        end
        S_RUN: begin
          wr_ready_q <= 1'b1;
          rd_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= S_RESET;
          wr_ready_q <= 1'b0;
          rd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      mem_q[w_clr_addr] <= '0;
    end else if (w_wr_we) begin
      for (int b = 0; b < c_num_bytes; b++) begin
        if (wr_be_i[b]) begin
          mem_q[w_wr_idx][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_rd_word = mem_q[w_rd_idx];
    w_merged  = w_rd_word;
    for (int b = 0; b < c_num_bytes; b++) begin
      if (wr_be_i[b]) begin
        w_merged[8*b +: 8] = wr_data_i[8*b +: 8];
      end
    end
    rd_data_d = '0;
    if (w_rd_in_range) begin
      rd_data_d = (WR_FIRST != 0 && w_wr_we && wr_addr_i == rd_addr_i) ? w_merged : w_rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1_q <= 1'b0;
      rd_d1_q <= '0;
    end else begin
      rd_v1_q <= w_rd_fire;
      if (w_rd_fire) begin
        rd_d1_q <= rd_data_d;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  rd_v2_q;
    logic [DATA_WIDTH-1:0] rd_d2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_v2_q <= 1'b0;
        rd_d2_q <= '0;
      end else begin
        rd_v2_q <= rd_v1_q;
        if (rd_v1_q) begin
          rd_d2_q <= rd_d1_q;
        end
      end
    end

    assign rd_rvalid_o = rd_v2_q;
    assign rd_data_o   = rd_d2_q;
  end else begin : g_no_out_reg
    assign rd_rvalid_o = rd_v1_q;
    assign rd_data_o   = rd_d1_q;
  end

  assign wr_ready_o = wr_ready_q;
  assign rd_ready_o = rd_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_fake_sram_1r1w.sv
// ============================================================================
// Module   : tb_fake_sram_1r1w
// Brief    : Self-checking bench; instance A (OUT_REG=0, WR_FIRST=1) and
//            instance B (OUT_REG=1, WR_FIRST=0) share one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fake_sram_1r1w;

  localparam int AW    = 5;
  localparam int DEPTH = 16;
`ifdef FAKE_SRAM_1R1W_CLEAR_EN
  localparam int RDY_LAT = DEPTH;
`else
  localparam int RDY_LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [3:0]    wr_be = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          rd_valid = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic          a_wr_ready, a_rd_ready, a_rv;
  logic [31:0]   a_rdata;
  logic          b_wr_ready, b_rd_ready, b_rv;
  logic [31:0]   b_rdata;

  always #5 clk = ~clk;

  fake_sram_1r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUT_REG(0), .WR_FIRST(1)) u_a (
    .clk(clk), .rst(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(a_wr_ready), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
    .rd_valid_i(rd_valid), .rd_ready_o(a_rd_ready), .rd_addr_i(rd_addr),
    .rd_rvalid_o(a_rv), .rd_data_o(a_rdata));

  fake_sram_1r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUT_REG(1), .WR_FIRST(0)) u_b (
    .clk(clk), .rst(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(b_wr_ready), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
    .rd_valid_i(rd_valid), .rd_ready_o(b_rd_ready), .rd_addr_i(rd_addr),
    .rd_rvalid_o(b_rv), .rd_data_o(b_rdata));

  // Reference model: word array plus per-instance queues of (due edge, data).
  typedef struct { int due; logic [31:0] data; } rd_t;
  logic [31:0] mdl_mem [DEPTH];
  rd_t         qa[$];
  rd_t         qb[$];
  int          cyc = 0;
  int          since = 0;
  bit          rdy = 1'b0;
  logic        ea_v = 1'b0, eb_v = 1'b0;
  logic [31:0] ea_d = '0, eb_d = '0;
  int          checks = 0;
  int          fails = 0;

  task automatic tick(input logic r, input logic wv, input logic [3:0] be, input logic [AW-1:0] wa,
                      input logic [31:0] wd, input logic rv, input logic [AW-1:0] ra);
    logic [31:0] oldw;
    logic [31:0] neww;
    rd_t         e;
    rst = r; wr_valid = wv; wr_be = be; wr_addr = wa; wr_data = wd; rd_valid = rv; rd_addr = ra;
    @(posedge clk);
    cyc++;
    if (r) begin
      qa.delete(); qb.delete();
      ea_d = '0; eb_d = '0;
      since = 0;
    end else begin
      if (rdy) begin
        oldw = (ra < DEPTH) ? mdl_mem[ra] : 32'h0;
        neww = 32'h0;
        if (wv && wa < DEPTH) begin
          neww = mdl_mem[wa];
          for (int b = 0; b < 4; b++) if (be[b]) neww[8*b +: 8] = wd[8*b +: 8];
        end
        if (rv) begin
          e.due = cyc;     e.data = (wv && wa == ra && ra < DEPTH) ? neww : oldw; qa.push_back(e);
          e.due = cyc + 1; e.data = oldw;                                          qb.push_back(e);
        end
        if (wv && wa < DEPTH) mdl_mem[wa] = neww;
      end
      since++;
`ifdef FAKE_SRAM_1R1W_CLEAR_EN
      if (since == RDY_LAT) for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
`endif
    end
    rdy = !r && (since >= RDY_LAT);
    ea_v = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin ea_v = 1'b1; ea_d = qa[0].data; void'(qa.pop_front()); end
    eb_v = 1'b0;
    if (qb.size() > 0 && qb[0].due == cyc) begin eb_v = 1'b1; eb_d = qb[0].data; void'(qb.pop_front()); end
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 4'h0, '0, '0, 1'b0, '0);
      checks++;
      if ({a_wr_ready, a_rd_ready, a_rv, b_wr_ready, b_rd_ready, b_rv} !== 6'b0 || a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
        fails++;
        $display("FAIL reset cyc=%0d got rdy=%b%b%b%b rv=%b%b data=%h/%h want all zero",
                 cyc, a_wr_ready, a_rd_ready, b_wr_ready, b_rd_ready, a_rv, b_rv, a_rdata, b_rdata);
      end
    end
  endtask

  task automatic test_ready_latency;
    int first = -1;
    tick(1'b1, 1'b0, 4'h0, '0, '0, 1'b0, '0);
    for (int n = 1; n <= RDY_LAT + 2; n++) begin
      tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
      checks++;
      if (a_rv !== ea_v || a_rdata !== ea_d || b_rv !== eb_v || b_rdata !== eb_d ||
          a_wr_ready !== rdy || a_rd_ready !== rdy || b_wr_ready !== rdy || b_rd_ready !== rdy) begin
        fails++;
        $display("FAIL ready_latency cyc=%0d got rv=%b%b data=%h/%h rdy=%b%b%b%b want rv=%b%b data=%h/%h rdy=%b",
                 cyc, a_rv, b_rv, a_rdata, b_rdata, a_wr_ready, a_rd_ready, b_wr_ready, b_rd_ready, ea_v, eb_v, ea_d, eb_d, rdy);
      end
      if (first < 0 && a_rd_ready === 1'b1 && b_wr_ready === 1'b1) first = n;
    end
    checks++;
    if (first != RDY_LAT) begin
      fails++;
      $display("FAIL ready_cycles got %0d want %0d", first, RDY_LAT);
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b0, 1'b1, 4'hF, AW'(i), $urandom, 1'b0, '0);
      checks++;
      if (a_rv !== ea_v || a_rdata !== ea_d || b_rv !== eb_v || b_rdata !== eb_d || a_wr_ready !== rdy || b_rd_ready !== rdy) begin
        fails++;
        $display("FAIL fill cyc=%0d got rv=%b%b data=%h/%h want rv=%b%b data=%h/%h", cyc, a_rv, b_rv, a_rdata, b_rdata, ea_v, eb_v, ea_d, eb_d);
      end
    end
  endtask

  task automatic test_basic;
    tick(1'b0, 1'b1, 4'hF, 5'd5, 32'hDEADBEEF, 1'b0, '0);
    tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 5'd5);
    checks++;
    if (a_rv !== 1'b1 || a_rdata !== 32'hDEADBEEF || b_rv !== 1'b0) begin
      fails++;
      $display("FAIL basic_lat1 got a=%b/%h b_rv=%b want a=1/deadbeef b_rv=0", a_rv, a_rdata, b_rv);
    end
    tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
    checks++;
    if (b_rv !== 1'b1 || b_rdata !== 32'hDEADBEEF || a_rv !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL basic_lat2 got b=%b/%h a=%b/%h want b=1/deadbeef a=0/deadbeef", b_rv, b_rdata, a_rv, a_rdata);
    end
    tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_byte_enable;
    tick(1'b0, 1'b1, 4'hF, 5'd3, 32'h11223344, 1'b0, '0);
    tick(1'b0, 1'b1, 4'b0101, 5'd3, 32'hAABBCCDD, 1'b0, '0);
    tick(1'b0, 1'b1, 4'h0, 5'd3, 32'h99999999, 1'b1, 5'd3);
    checks++;
    if (a_rv !== 1'b1 || a_rdata !== 32'h11BB33DD) begin
      fails++;
      $display("FAIL byte_enable got %b/%h want 1/11bb33dd", a_rv, a_rdata);
    end
    tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
    checks++;
    if (b_rv !== 1'b1 || b_rdata !== 32'h11BB33DD) begin
      fails++;
      $display("FAIL byte_enable_b got %b/%h want 1/11bb33dd", b_rv, b_rdata);
    end
  endtask

  task automatic test_collision;
    tick(1'b0, 1'b1, 4'hF, 5'd7, 32'h0, 1'b0, '0);
    tick(1'b0, 1'b1, 4'hF, 5'd7, 32'hFFFFFFFF, 1'b1, 5'd7);
    checks++;
    if (a_rv !== 1'b1 || a_rdata !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL collision_wr_first got %b/%h want 1/ffffffff", a_rv, a_rdata);
    end
    tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
    checks++;
    if (b_rv !== 1'b1 || b_rdata !== 32'h00000000) begin
      fails++;
      $display("FAIL collision_rd_first got %b/%h want 1/00000000", b_rv, b_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int na = 0, nb = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 4'h0, '0, '0, (i < 4), AW'(i));
      checks++;
      if (a_rv !== ea_v || a_rdata !== ea_d || b_rv !== eb_v || b_rdata !== eb_d) begin
        fails++;
        $display("FAIL back_to_back cyc=%0d got rv=%b%b data=%h/%h want rv=%b%b data=%h/%h", cyc, a_rv, b_rv, a_rdata, b_rdata, ea_v, eb_v, ea_d, eb_d);
      end
      if (a_rv === 1'b1) na++;
      if (b_rv === 1'b1) nb++;
    end
    checks++;
    if (na != 4 || nb != 4) begin
      fails++;
      $display("FAIL back_to_back_count got %0d/%0d want 4/4", na, nb);
    end
  endtask

  task automatic test_out_of_range;
    tick(1'b0, 1'b1, 4'hF, 5'd20, 32'h12345678, 1'b0, '0);
    tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 5'd20);
    checks++;
    if (a_rv !== 1'b1 || a_rdata !== 32'h0) begin
      fails++;
      $display("FAIL out_of_range got %b/%h want 1/00000000", a_rv, a_rdata);
    end
    tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 5'd4);
    checks++;
    if (a_rv !== ea_v || a_rdata !== ea_d || b_rv !== 1'b1 || b_rdata !== 32'h0) begin
      fails++;
      $display("FAIL out_of_range_alias got a=%b/%h b=%b/%h want a=%b/%h b=1/00000000", a_rv, a_rdata, b_rv, b_rdata, ea_v, ea_d);
    end
    tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'($urandom), 4'($urandom), AW'($urandom_range(23, 0)), $urandom,
           1'($urandom), AW'($urandom_range(23, 0)));
      checks++;
      if (a_rv !== ea_v || a_rdata !== ea_d || b_rv !== eb_v || b_rdata !== eb_d ||
          a_wr_ready !== rdy || a_rd_ready !== rdy || b_wr_ready !== rdy || b_rd_ready !== rdy) begin
        fails++;
        $display("FAIL random cyc=%0d got rv=%b%b data=%h/%h want rv=%b%b data=%h/%h", cyc, a_rv, b_rv, a_rdata, b_rdata, ea_v, eb_v, ea_d, eb_d);
      end
    end
  endtask

  task automatic test_reset_midflight;
    logic [31:0] want;
`ifdef FAKE_SRAM_1R1W_CLEAR_EN
    want = 32'h0;
`else
    want = 32'h5A5A1234;
`endif
    tick(1'b0, 1'b1, 4'hF, 5'd9, 32'h5A5A1234, 1'b0, '0);
    tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 5'd9);
    tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 5'd9);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 4'h0, '0, '0, 1'b0, '0);
      checks++;
      if (a_rv !== 1'b0 || b_rv !== 1'b0 || a_rd_ready !== 1'b0) begin
        fails++;
        $display("FAIL reset_midflight cyc=%0d got rv=%b%b rdy=%b want 0 0 0", cyc, a_rv, b_rv, a_rd_ready);
      end
    end
    for (int i = 0; i < RDY_LAT; i++) begin
      tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
      checks++;
      if (a_rv !== ea_v || b_rv !== eb_v || a_rd_ready !== rdy || b_wr_ready !== rdy) begin
        fails++;
        $display("FAIL reset_recover cyc=%0d got rv=%b%b rdy=%b%b want rv=%b%b rdy=%b", cyc, a_rv, b_rv, a_rd_ready, b_wr_ready, ea_v, eb_v, rdy);
      end
    end
    tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 5'd9);
    tick(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, '0);
    checks++;
    if (a_rdata !== want || b_rv !== 1'b1 || b_rdata !== want) begin
      fails++;
      $display("FAIL reset_persist got a=%h b=%b/%h want %h", a_rdata, b_rv, b_rdata, want);
    end
  endtask

  task automatic test_clear_contents;
    int nz = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      tick(1'b0, 1'b0, 4'h0, '0, '0, (i < DEPTH), AW'(i));
      if ((a_rv === 1'b1 && a_rdata !== mdl_mem[i]) || a_rv !== ea_v || a_rdata !== ea_d) nz++;
    end
    checks++;
    if (nz != 0) begin
      fails++;
      $display("FAIL clear_contents got %0d bad reads want 0", nz);
    end
  endtask

  initial begin
    test_reset();
    test_ready_latency();
    test_clear_contents();
    test_fill();
    test_basic();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
